// File: rtl/exe_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide over a shared accumulator, BITS_PER_CYCLE bits per CALC cycle.
module exe_muldiv #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_v_i,
   output logic            req_rdy_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_adr_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            res_v_o,
   output logic [4:0]      res_adr_o,
   output logic [XLEN-1:0] res_data_o
);

   localparam int N     = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int ACC_W = 2 * XLEN + 1;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [4:0]         rd_q, rd_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    opb_q, opb_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               res_v_q, res_v_d;
   logic [4:0]         res_adr_q, res_adr_d;
   logic [XLEN-1:0]    res_data_q, res_data_d;

   logic               s1, s2, is_div;
   logic [XLEN-1:0]    mag1, mag2;

   function automatic logic [XLEN-1:0] negx(input logic [XLEN-1:0] x, input logic neg);
      logic signed [XLEN-1:0] xs;
      xs = $signed(x);
      return neg ? $unsigned(-xs) : x;
   endfunction

   function automatic logic [2*XLEN-1:0] neg2x(input logic [2*XLEN-1:0] x, input logic neg);
      logic signed [2*XLEN-1:0] xs;
      xs = $signed(x);
      return neg ? $unsigned(-xs) : x;
   endfunction

   // Accumulator {hi[XLEN:0], lo[XLEN-1:0]}: lo holds the multiplier, product builds from the top.
   function automatic logic [ACC_W-1:0] mul_step(input logic [ACC_W-1:0] acc, input logic [XLEN-1:0] mcand);
      logic [ACC_W-1:0] a;
      logic [XLEN:0]    hi;
      a = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         hi = a[2*XLEN:XLEN];
         if (a[0]) hi = hi + {1'b0, mcand};
         a = {1'b0, hi, a[XLEN-1:1]};
      end
      return a;
   endfunction

   // hi is the partial remainder, lo shifts the dividend out and the quotient in.
   function automatic logic [ACC_W-1:0] div_step(input logic [ACC_W-1:0] acc, input logic [XLEN-1:0] dvs);
      logic [ACC_W-1:0] a;
      a = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         a = {a[2*XLEN-1:0], 1'b0};
         if (a[2*XLEN:XLEN] >= {1'b0, dvs}) begin
            a[2*XLEN:XLEN] = a[2*XLEN:XLEN] - {1'b0, dvs};
            a[0]           = 1'b1;
         end
      end
      return a;
   endfunction

   function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic [ACC_W-1:0] acc,
                                             input logic neg, input logic rneg,
                                             input logic dbz, input logic ovf);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo, rem, r;
      prod = neg2x(acc[2*XLEN-1:0], neg);
      quo  = negx(acc[XLEN-1:0], neg);
      // With a zero divisor the remainder is |rs1| re-signed, i.e. rs1 itself.
      rem  = negx(acc[2*XLEN-1:XLEN], rneg);
      case (op)
         OP_MUL:                       r = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: r = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              r = dbz ? '1 : (ovf ? MOST_NEG : quo);
         default:                      r = ovf ? '0 : rem;
      endcase
      return r;
   endfunction

   assign is_div = op_i[2];
   assign s1     = rs1_data_i[XLEN-1] &
                   ((op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM));
   assign s2     = rs2_data_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM));
   assign mag1   = negx(rs1_data_i, s1);
   assign mag2   = negx(rs2_data_i, s2);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd_d       = rd_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      dbz_d      = dbz_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      res_v_d    = 1'b0;
      res_adr_d  = res_adr_q;
      res_data_d = res_data_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (req_v_i) begin
               state_d = S_CALC;
               op_d    = op_i;
               rd_d    = rd_adr_i;
               neg_d   = s1 ^ s2;
               rneg_d  = s1;
               dbz_d   = (rs2_data_i == '0);
               ovf_d   = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                         (rs1_data_i == MOST_NEG) & (rs2_data_i == '1);
               cnt_d   = '0;
               opb_d   = is_div ? mag2 : mag1;
               acc_d   = {{(XLEN+1){1'b0}}, (is_div ? mag1 : mag2)};
            end
            S_CALC: begin
               acc_d = op_q[2] ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N-1)) state_d = S_FIXUP;
            end
            S_FIXUP: begin
               state_d    = S_IDLE;
               res_v_d    = 1'b1;
               res_adr_d  = rd_q;
               res_data_d = fixup(op_q, acc_q, neg_q, rneg_q, dbz_q, ovf_q);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      op_q   <= op_d;
      rd_q   <= rd_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      opb_q  <= opb_d;
      acc_q  <= acc_d;
      if (!reset_n) begin
         state_q    <= S_IDLE;
         res_v_q    <= 1'b0;
         res_adr_q  <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         res_v_q    <= res_v_d;
         res_adr_q  <= res_adr_d;
         res_data_q <= res_data_d;
      end
   end

   assign req_rdy_o  = (state_q == S_IDLE);
   assign busy_o     = (state_q != S_IDLE);
   assign res_v_o    = res_v_q;
   assign res_adr_o  = res_adr_q;
   assign res_data_o = res_data_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Randomised and directed bench for exe_muldiv (32-bit/1 bpc and 64-bit/4 bpc
// instances) against an arithmetic reference model.
module tb_exe_muldiv;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_v_a, req_v_b, flush;
   logic [2:0]  op;
   logic [63:0] rs1, rs2;
   logic [4:0]  rd;

   logic        rdy_a, busy_a, resv_a;
   logic [4:0]  adr_a;
   logic [31:0] data_a;
   logic        rdy_b, busy_b, resv_b;
   logic [4:0]  adr_b;
   logic [63:0] data_b;

   logic        sel;
   logic        rdy_m, busy_m, resv_m;
   logic [4:0]  adr_m;
   logic [63:0] data_m;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exe_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .req_v_i(req_v_a), .req_rdy_o(rdy_a), .op_i(op),
      .rs1_data_i(rs1[31:0]), .rs2_data_i(rs2[31:0]), .rd_adr_i(rd), .flush_i(flush),
      .busy_o(busy_a), .res_v_o(resv_a), .res_adr_o(adr_a), .res_data_o(data_a));

   exe_muldiv #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .req_v_i(req_v_b), .req_rdy_o(rdy_b), .op_i(op),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_adr_i(rd), .flush_i(flush),
      .busy_o(busy_b), .res_v_o(resv_b), .res_adr_o(adr_b), .res_data_o(data_b));

   assign rdy_m  = sel ? rdy_b  : rdy_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign resv_m = sel ? resv_b : resv_a;
   assign adr_m  = sel ? adr_b  : adr_a;
   assign data_m = sel ? data_b : {32'd0, data_a};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input int xlen, input logic [2:0] f3,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb;
      logic [127:0]        ua, ub, p;
      logic [63:0]         mask, minv, r;
      logic                ovf;
      mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
      minv = (xlen == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      if (xlen == 32) begin
         sa = {{96{a[31]}}, a[31:0]};
         sb = {{96{b[31]}}, b[31:0]};
         ua = {96'd0, a[31:0]};
         ub = {96'd0, b[31:0]};
      end else begin
         sa = {{64{a[63]}}, a};
         sb = {{64{b[63]}}, b};
         ua = {64'd0, a};
         ub = {64'd0, b};
      end
      ovf = ((a & mask) == minv) && ((b & mask) == mask);
      p = '0;
      case (f3)
         3'd0: p = sa * sb;
         3'd1: p = sa * sb;
         3'd2: p = sa * $signed(ub);
         3'd3: p = ua * ub;
         default: p = '0;
      endcase
      case (f3)
         3'd0:             r = p[63:0];
         3'd1, 3'd2, 3'd3: r = (xlen == 32) ? {32'd0, p[63:32]} : p[127:64];
         3'd4:             r = (ub == 0) ? mask : (ovf ? minv : 64'(sa / sb));
         3'd5:             r = (ub == 0) ? mask : 64'(ua / ub);
         3'd6:             r = (ub == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
         default:          r = (ub == 0) ? a : 64'(ua % ub);
      endcase
      return r & mask;
   endfunction

   function automatic logic [63:0] pick(input int xlen);
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = (xlen == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
         3:       v = 64'($urandom_range(0, 9));
         default: v = {$urandom, $urandom};
      endcase
      return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
   endfunction

   // Called at #1 after a rising edge with the selected unit idle.
   task automatic do_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rda, input string tag);
      int          k, lat_exp, xl;
      logic        got;
      logic [63:0] exp;
      xl      = sel ? 64 : 32;
      lat_exp = sel ? 17 : 33;
      exp     = ref_model(xl, f3, a, b);
      op = f3; rs1 = a; rs2 = b; rd = rda;
      if (sel) req_v_b = 1'b1; else req_v_a = 1'b1;
      @(posedge clk); #1;
      req_v_a = 1'b0; req_v_b = 1'b0;
      chk({tag, "_busy"}, 64'(busy_m), 64'd1);
      k = 0; got = 1'b0;
      while (!got && k < 200) begin
         @(posedge clk); #1;
         k++;
         got = resv_m;
      end
      chk({tag, "_lat"}, 64'(k), 64'(lat_exp));
      chk({tag, "_data"}, data_m, exp);
      chk({tag, "_adr"}, 64'(adr_m), 64'(rda));
      chk({tag, "_rdy"}, 64'(rdy_m), 64'd1);
   endtask

   logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd13,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd2, 32'd4, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

   initial begin
      int   k, t1, t2;
      logic seen;
      reset_n = 1'b0; req_v_a = 1'b0; req_v_b = 1'b0; flush = 1'b0;
      op = '0; rs1 = '0; rs2 = '0; rd = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", 64'(rdy_a), 64'd1);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_resv", 64'(resv_a), 64'd0);
      chk("rst_adr", 64'(adr_a), 64'd0);
      chk("rst_data", 64'(data_a), 64'd0);
      chk("rst_rdy64", 64'(rdy_b), 64'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed values, also cross-checking the model against hand results
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("model%0d", i), ref_model(32, d_op[i], 64'(d_a[i]), 64'(d_b[i])), 64'(d_exp[i]));
         do_op(d_op[i], 64'(d_a[i]), 64'(d_b[i]), 5'(i + 1), $sformatf("dir%0d", i));
      end

      for (int i = 0; i < 24; i++)
         do_op(3'($urandom_range(0, 7)), pick(32), pick(32), 5'($urandom_range(0, 31)),
               $sformatf("rnd32_%0d", i));

      // Flush at E10 of a DIV
      op = 3'd4; rs1 = 64'd100; rs2 = 64'd7; rd = 5'd3; req_v_a = 1'b1;
      @(posedge clk); #1;
      req_v_a = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_rdy", 64'(rdy_a), 64'd1);
      chk("flush_busy", 64'(busy_a), 64'd0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (resv_a) seen = 1'b1; end
      chk("flush_nores", 64'(seen), 64'd0);
      do_op(3'd0, 64'd3, 64'd4, 5'd7, "post_flush");

      // Flush on the FIXUP edge cancels the result; outputs hold the previous one
      op = 3'd5; rs1 = 64'd99; rs2 = 64'd5; rd = 5'd12; req_v_a = 1'b1;
      @(posedge clk); #1;
      req_v_a = 1'b0;
      repeat (32) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      seen = resv_a;
      repeat (5) begin @(posedge clk); #1; if (resv_a) seen = 1'b1; end
      chk("fixflush_nores", 64'(seen), 64'd0);
      chk("fixflush_hold_data", 64'(data_a), 64'd12);
      chk("fixflush_hold_adr", 64'(adr_a), 64'd7);

      // Request coinciding with flush is not accepted
      req_v_a = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_v_a = 1'b0; flush = 1'b0;
      chk("reqflush_busy", 64'(busy_a), 64'd0);

      // Reset in mid-CALC
      op = 3'd4; rs1 = 64'd1000; rs2 = 64'd3; rd = 5'd20; req_v_a = 1'b1;
      @(posedge clk); #1;
      req_v_a = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_rdy", 64'(rdy_a), 64'd1);
      chk("midrst_busy", 64'(busy_a), 64'd0);
      chk("midrst_resv", 64'(resv_a), 64'd0);
      chk("midrst_adr", 64'(adr_a), 64'd0);
      chk("midrst_data", 64'(data_a), 64'd0);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (resv_a) seen = 1'b1; end
      chk("midrst_nores", 64'(seen), 64'd0);

      // Back-to-back: second request held high while busy
      op = 3'd0; rs1 = 64'd6; rs2 = 64'd7; rd = 5'd9; req_v_a = 1'b1;
      @(posedge clk); #1;
      op = 3'd5; rs1 = 64'd100; rs2 = 64'd7; rd = 5'd10;
      k = 0; t1 = 0; t2 = 0;
      while (t2 == 0 && k < 150) begin
         @(posedge clk); #1;
         k++;
         if (t1 != 0 && k == t1 + 1) begin
            chk("b2b_accept", 64'(busy_a), 64'd1);
            req_v_a = 1'b0;
         end
         if (resv_a) begin
            if (t1 == 0) begin
               t1 = k;
               chk("b2b_first_data", 64'(data_a), 64'd42);
               chk("b2b_first_adr", 64'(adr_a), 64'd9);
               chk("b2b_first_rdy", 64'(rdy_a), 64'd1);
            end else begin
               t2 = k;
               chk("b2b_second_data", 64'(data_a), 64'd14);
               chk("b2b_second_adr", 64'(adr_a), 64'd10);
            end
         end
      end
      req_v_a = 1'b0;
      chk("b2b_first_lat", 64'(t1), 64'd33);
      chk("b2b_gap", 64'(t2 - t1), 64'd34);

      // 64-bit, 4 bits per cycle
      sel = 1'b1;
      do_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd17, "divu64");
      chk("divu64_val", data_b, 64'h5555_5555_5555_5555);
      for (int i = 0; i < 16; i++)
         do_op(3'($urandom_range(0, 7)), pick(64), pick(64), 5'($urandom_range(0, 31)),
               $sformatf("rnd64_%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
